// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and FSM encoding for the data-memory line responder
package dmem_pkg;

    localparam int ADDR_W         = 28;
    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// rtl/dmem_line_array.sv - line storage, synchronous write and combinational read
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [LINE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [LINE_W-1:0] rdata
);

    // Contents are deliberately not reset; the array models backing memory.
    logic [LINE_W-1:0] lines [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            lines[widx] <= wdata;
        end
    end

    assign rdata = lines[ridx];

endmodule

// File: rtl/dmem_line_responder.sv
// rtl/dmem_line_responder.sv - fixed-latency line read/write responder with busywait handshake
module dmem_line_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_writedata,
    output logic [LINE_W-1:0] mem_readdata,
    output logic              mem_busywait
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    state_t            state, state_n;
    logic [7:0]        count, count_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic              op_write, op_write_n;
    logic [LINE_W-1:0] readdata_n;
    logic [LINE_W-1:0] array_rdata;
    logic              commit_write;
    logic              req;
    logic              unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign unused_addr_bits = ^mem_address[ADDR_W-1:IDX_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            idx          <= '0;
            op_write     <= 1'b0;
            mem_readdata <= '0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            idx          <= idx_n;
            op_write     <= op_write_n;
            mem_readdata <= readdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        count_n      = count;
        idx_n        = idx;
        op_write_n   = op_write;
        readdata_n   = mem_readdata;
        commit_write = 1'b0;
        mem_busywait = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_busywait = 1'b1;
                    idx_n        = mem_address[IDX_W-1:0];
                    op_write_n   = mem_write;
                    count_n      = LAT_M1;
                    state_n      = ACCESS;
                end
            end
            ACCESS: begin
                mem_busywait = 1'b1;
                if (!req) begin
                    state_n = IDLE;
                end else if (count != 8'd0) begin
                    count_n = count - 8'd1;
                end else begin
                    if (op_write) begin
                        commit_write = 1'b1;
                    end else begin
                        readdata_n = array_rdata;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                // Request is still high here but already served; ignore it.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Reset on the final access cycle must not let the write land.
    dmem_line_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (commit_write & ~reset),
        .widx  (idx),
        .wdata (mem_writedata),
        .ridx  (idx),
        .rdata (array_rdata)
    );

endmodule

// File: tb/tb_dmem_line_responder.sv
// tb/tb_dmem_line_responder.sv - scoreboard bench with random traffic against a line-array model
module tb_dmem_line_responder;

    localparam int LAT = 5;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [27:0]  mem_address = '0;
    logic [127:0] mem_writedata = '0;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    dmem_line_responder #(.DEPTH(256), .LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           is_read;
        bit           known;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model [256];
    bit           known [256];
    logic [127:0] last_rd = '0;
    bit           last_known = 1'b1;
    int           checks = 0;
    int           errors = 0;
    int           busy_cnt = 0;
    exp_t         mon_e;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion = request high while busywait is low (the DONE cycle).
    always @(negedge clock) begin
        if (reset) begin
            busy_cnt = 0;
        end else if (mem_read || mem_write) begin
            if (mem_busywait) begin
                busy_cnt++;
            end else begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("busy_cycles", 128'(busy_cnt), 128'(LAT + 1));
                    if (mon_e.is_read && mon_e.known)
                        chk("read_data", mem_readdata, mon_e.data);
                end
                busy_cnt = 0;
            end
        end else begin
            busy_cnt = 0;
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        exp_t e;
        bit   done;
        int   i;
        i = int'(a[7:0]);
        if (wr) begin
            model[i] = d;
            known[i] = 1'b1;
            e = '{is_read: 1'b0, known: 1'b0, data: d};
        end else begin
            e = '{is_read: 1'b1, known: known[i], data: model[i]};
        end
        sb.push_back(e);
        mem_read = rd;
        mem_write = wr;
        mem_address = a;
        mem_writedata = d;
        @(negedge clock);
        chk("busy_rise", 128'(mem_busywait), 128'(1));
        done = 1'b0;
        for (int n = 0; n < LAT + 10 && !done; n++) begin
            if (!mem_busywait) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got busywait stuck high expected low within %0d cycles", LAT + 10);
        end
        @(posedge clock);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        if (!wr) begin
            last_rd = e.data;
            last_known = e.known;
        end
    endtask

    task automatic abort_req(input bit wr, input logic [27:0] a, input logic [127:0] d, input int k);
        mem_read = ~wr;
        mem_write = wr;
        mem_address = a;
        mem_writedata = d;
        repeat (k) begin
            @(posedge clock);
            #1;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("abort_busy_low", 128'(mem_busywait), 128'(0));
        if (last_known) chk("abort_readdata_held", mem_readdata, last_rd);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_during(input logic [27:0] a, input logic [127:0] d, input int k, input bit hold);
        mem_write = 1'b1;
        mem_address = a;
        mem_writedata = d;
        repeat (k) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        mem_write = hold;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mem_write = 1'b0;
        @(negedge clock);
        chk("rst_busy_low", 128'(mem_busywait), 128'(0));
        chk("rst_readdata_zero", mem_readdata, 128'(0));
        last_rd = '0;
        last_known = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d2;
        logic [31:0]  r;
        int           op;
        int           gap;
        for (int i = 0; i < 256; i++) known[i] = 1'b0;

        // Reset with no requests
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            chk("idle_busy", 128'(mem_busywait), 128'(0));
            chk("idle_readdata", mem_readdata, 128'(0));
        end
        @(posedge clock);
        #1;

        // Write then read of line 0x12, readdata held after the read drops
        d2 = {32'hDEAD_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        do_req(1'b0, 1'b1, 28'h000_0012, d2);
        do_req(1'b1, 1'b0, 28'h000_0012, '0);
        repeat (3) @(negedge clock);
        chk("readdata_hold", mem_readdata, d2);
        @(posedge clock);
        #1;

        // Back-to-back write-back then aliased refill
        do_req(1'b0, 1'b1, 28'h000_0040, rand_line());
        do_req(1'b1, 1'b0, 28'h000_0140, '0);

        // Simultaneous read and write: write wins
        do_req(1'b1, 1'b1, 28'h000_0005, {4{32'hA5A5_A5A5}});
        do_req(1'b1, 1'b0, 28'h000_0005, '0);

        // Reset in ACCESS cycle 2, reset on the final cycle with write held, and a dropped write
        do_req(1'b0, 1'b1, 28'h000_0007, rand_line());
        reset_during(28'h000_0007, rand_line(), 2, 1'b0);
        do_req(1'b1, 1'b0, 28'h000_0007, '0);
        reset_during(28'h000_0007, rand_line(), LAT, 1'b1);
        do_req(1'b1, 1'b0, 28'h000_0007, '0);
        abort_req(1'b1, 28'h000_0007, rand_line(), 3);
        do_req(1'b1, 1'b0, 28'h000_0007, '0);

        // Randomized traffic with gaps, aborts and aliased addresses
        for (int t = 0; t < 200; t++) begin
            r = $urandom;
            op = int'($urandom_range(0, 11));
            if (op == 0) begin
                abort_req(r[0], r[27:0], rand_line(), int'($urandom_range(1, LAT)));
            end else if (op <= 5) begin
                do_req(1'b1, 1'b0, {r[27:8], 8'(r[7:0] & 8'h1F)}, '0);
            end else if (op <= 9) begin
                do_req(1'b0, 1'b1, {r[27:8], 8'(r[7:0] & 8'h1F)}, rand_line());
            end else begin
                do_req(1'b1, 1'b1, {r[27:8], 8'(r[7:0] & 8'h1F)}, rand_line());
            end
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
        end

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
